opc5_uart_tx_responder: RTL

OPC5_UART_TX_RESPONDER -- requirements
Module: opc5_uart_tx_responder

---
 rtl/opc5_io_pkg.sv | 49 ++++
 rtl/opc5_sync_fifo.sv | 75 +++++++
 rtl/opc5_uart_tx_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/opc5_io_pkg.sv
// Shared definitions for the OPC5 memory-mapped UART transmitter:
// register offsets, STATUS/CTRL bit positions and the transmit FSM encoding.
package opc5_io_pkg;

    // Word offsets of the four registers inside the peripheral window
    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_TXDATA  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // STATUS read layout: {8'b0, overflow, count[3:0], tx_busy, empty, full}
    localparam int STATUS_FULL_BIT     = 0;
    localparam int STATUS_EMPTY_BIT    = 1;
    localparam int STATUS_BUSY_BIT     = 2;
    localparam int STATUS_COUNT_LSB    = 3;
    localparam int STATUS_COUNT_MSB    = 6;
    localparam int STATUS_OVERFLOW_BIT = 7;

    // CTRL bit positions
    localparam int CTRL_TX_EN_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // Transmit frame sequencer states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } txState_e;

    // Assemble the STATUS word from its individual flags
    function automatic logic [15:0] packStatus(
        input logic       overflow,
        input logic [3:0] count,
        input logic       busy,
        input logic       empty,
        input logic       full
    );
        logic [15:0] word;
        word = 16'h0000;
        word[STATUS_OVERFLOW_BIT]                   = overflow;
        word[STATUS_COUNT_MSB:STATUS_COUNT_LSB]     = count;
        word[STATUS_BUSY_BIT]                       = busy;
        word[STATUS_EMPTY_BIT]                      = empty;
        word[STATUS_FULL_BIT]                       = full;
        return word;
    endfunction

endpackage

// File: rtl/opc5_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is only
// accepted when a pop happens in the same cycle; otherwise it is dropped
// and the caller is expected to flag the overflow. DEPTH must be a power
// of two (at least 2) so the pointers wrap naturally.
module opc5_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    // Pointer and occupancy bookkeeping for the accepted push/pop pair
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and count clear on reset, which discards any stored bytes
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are meaningless once the pointers are reset
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/opc5_uart_tx_responder.sv
// Memory-mapped UART transmitter for the OPC5 CPU bus: four registers
// (STATUS, TXDATA, BAUDDIV, CTRL), a transmit FIFO and an 8N1 serialiser.
// Reads are side-effect free because the CPU also drives rnw=1 on fetches.
module opc5_uart_tx_responder
    import opc5_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFE00,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        rnw,
    inout  wire  [15:0] data,
    output logic        txd,
    output logic        irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Bus decode
    logic [15:0] regOffset;
    logic        inWindow;
    logic [1:0]  regSel;
    logic        readEn;
    logic        writeEn;
    logic [15:0] readData;

    // Configuration and sticky status registers
    logic [15:0] baudDiv_q, baudDiv_d;
    logic        txEn_q, txEn_d;
    logic        irqEn_q, irqEn_d;
    logic        overflow_q, overflow_d;

    // FIFO interface
    logic             fifoPush;
    logic             fifoPop;
    logic [7:0]       fifoHead;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CNT_W-1:0] fifoCount;
    logic [3:0]       countNibble;

    // Transmit sequencer
    txState_e    state_q, state_d;
    logic [15:0] baudCnt_q, baudCnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  shifter_q, shifter_d;
    logic        txd_q, txd_d;
    logic        bitDone;
    logic        txBusy;

    assign regOffset = address - BASE_ADDR;
    assign inWindow  = (regOffset < 16'd4);
    assign regSel    = regOffset[1:0];
    assign readEn    = rnw && inWindow;
    assign writeEn   = !rnw && inWindow;

    assign txBusy      = (state_q != TX_IDLE);
    assign countNibble = 4'(fifoCount);
    assign fifoPush    = writeEn && (regSel == REG_TXDATA);

    assign data = readEn ? readData : 16'hzzzz;
    assign txd  = txd_q;
    assign irq  = irqEn_q && fifoEmpty && !txBusy;

    // Read multiplexer; TXDATA is write-only and reads back as zero
    always_comb begin
        readData = 16'h0000;
        case (regSel)
            REG_STATUS:  readData = packStatus(overflow_q, countNibble, txBusy,
                                               fifoEmpty, fifoFull);
            REG_TXDATA:  readData = 16'h0000;
            REG_BAUDDIV: readData = baudDiv_q;
            REG_CTRL: begin
                readData[CTRL_TX_EN_BIT]  = txEn_q;
                readData[CTRL_IRQ_EN_BIT] = irqEn_q;
            end
            default:     readData = 16'h0000;
        endcase
    end

    // Register writes; overflow is set by a dropped push and cleared by a STATUS write with bit 7
    always_comb begin
        baudDiv_d  = baudDiv_q;
        txEn_d     = txEn_q;
        irqEn_d    = irqEn_q;
        overflow_d = overflow_q;
        if (fifoPush && fifoFull && !fifoPop) begin
            overflow_d = 1'b1;
        end
        if (writeEn) begin
            case (regSel)
                REG_STATUS: begin
                    if (data[STATUS_OVERFLOW_BIT]) begin
                        overflow_d = 1'b0;
                    end
                end
                REG_BAUDDIV: baudDiv_d = data;
                REG_CTRL: begin
                    txEn_d  = data[CTRL_TX_EN_BIT];
                    irqEn_d = data[CTRL_IRQ_EN_BIT];
                end
                default: ;
            endcase
        end
    end

    // Configuration register state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baudDiv_q  <= DEFAULT_DIV;
            txEn_q     <= 1'b0;
            irqEn_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            baudDiv_q  <= baudDiv_d;
            txEn_q     <= txEn_d;
            irqEn_q    <= irqEn_d;
            overflow_q <= overflow_d;
        end
    end

    opc5_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (fifoPush),
        .wdata_i (data[7:0]),
        .pop_i   (fifoPop),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign bitDone = (baudCnt_q == 16'd0);

    // Frame sequencer: txd_d is computed alongside the state so the output register changes with it
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        shifter_d = shifter_q;
        txd_d     = txd_q;
        fifoPop   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (txEn_q && !fifoEmpty) begin
                    fifoPop   = 1'b1;
                    shifter_d = fifoHead;
                    baudCnt_d = baudDiv_q;
                    bitIdx_d  = 3'd0;
                    txd_d     = 1'b0;
                    state_d   = TX_START;
                end
            end
            TX_START: begin
                if (bitDone) begin
                    baudCnt_d = baudDiv_q;
                    txd_d     = shifter_q[0];
                    state_d   = TX_DATA;
                end else begin
                    baudCnt_d = baudCnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (bitDone) begin
                    baudCnt_d = baudDiv_q;
                    if (bitIdx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        bitIdx_d  = bitIdx_q + 3'd1;
                        shifter_d = {1'b0, shifter_q[7:1]};
                        txd_d     = shifter_q[1];
                    end
                end else begin
                    baudCnt_d = baudCnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                txd_d = 1'b1;
                if (bitDone) begin
                    state_d = TX_IDLE;
                end else begin
                    baudCnt_d = baudCnt_q - 16'd1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = TX_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons a frame and returns the line high at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            baudCnt_q <= 16'd0;
            bitIdx_q  <= 3'd0;
            shifter_q <= 8'h00;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shifter_q <= shifter_d;
            txd_q     <= txd_d;
        end
    end

endmodule
